half_store_ctrl: RTL and testbench

HALF_STORE_CTRL -- requirements
Module: half_store_ctrl

---
 rtl/half_store_ctrl.sv | 106 ++++++++++
 tb/tb_half_store_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/half_store_ctrl.sv
// Store controller: word stores write straight through; halfword stores do a
// read-merge-write of the containing word. Misaligned requests are rejected.
module half_store_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              half_word_t,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;

  // Only the halfword path needs request fields beyond the acceptance cycle.
  typedef struct packed {
    logic        hi;
    logic [15:0] half;
  } hreq_t;

  state_t            state, state_nx;
  hreq_t             hreq, hreq_nx;
  logic              re_nx, we_nx, done_nx, err_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [31:0]       wdata_nx;
  logic              misaligned;

  assign req_ready  = (state == IDLE);
  assign misaligned = half_word_t ? req_addr[0] : (req_addr[1:0] != 2'b00);

  always_comb begin
    state_nx = state;
    hreq_nx  = hreq;
    re_nx    = 1'b0;
    we_nx    = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    addr_nx  = mem_addr;
    wdata_nx = mem_wdata;
    case (state)
      IDLE: if (req_valid) begin
        if (misaligned) begin
          // Rejects reuse WRITE as a one-cycle busy slot with no strobe.
          err_nx   = 1'b1;
          done_nx  = 1'b1;
          state_nx = WRITE;
        end else begin
          addr_nx = {req_addr[ADDR_W-1:2], 2'b00};
          if (half_word_t) begin
            re_nx    = 1'b1;
            hreq_nx  = '{hi: req_addr[1], half: req_data[15:0]};
            state_nx = READ;
          end else begin
            we_nx    = 1'b1;
            wdata_nx = req_data;
            done_nx  = 1'b1;
            state_nx = WRITE;
          end
        end
      end
      READ:  state_nx = MERGE;
      MERGE: begin
        // mem_rdata is valid this cycle (one after mem_re).
        we_nx    = 1'b1;
        done_nx  = 1'b1;
        wdata_nx = hreq.hi ? {hreq.half, mem_rdata[15:0]}
                           : {mem_rdata[31:16], hreq.half};
        state_nx = WRITE;
      end
      WRITE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hreq      <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nx;
      hreq      <= hreq_nx;
      mem_re    <= re_nx;
      mem_we    <= we_nx;
      done      <= done_nx;
      err       <= err_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
    end
  end

endmodule

// File: tb/tb_half_store_ctrl.sv
// Bench for half_store_ctrl: directed cases plus random stores checked cycle
// by cycle against a transaction-level schedule of expected strobes.
module tb_half_store_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        half_word_t = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_wdata;
  logic        done, err;

  logic [31:0] rd_val = '0;
  int          n_chk = 0;
  int          n_err = 0;

  half_store_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .half_word_t(half_word_t), .req_addr(req_addr), .req_data(req_data),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Memory returns the requested word only in the cycle after mem_re.
  always @(posedge clk) mem_rdata <= mem_re ? rd_val : $urandom();

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Present one store at a negedge in IDLE and check every cycle until ready.
  task automatic do_store(input bit hw, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] r);
    bit          mis;
    int          re_at, we_at, done_at, lat, sh;
    logic [31:0] exp_w, exp_a;
    mis     = hw ? a[0] : (a[1:0] != 2'b00);
    re_at   = (hw && !mis) ? 1 : 0;
    we_at   = mis ? 0 : (hw ? 3 : 1);
    done_at = mis ? 1 : we_at;
    lat     = (hw && !mis) ? 4 : 2;
    sh      = a[1] ? 16 : 0;
    exp_a   = a & ~32'd3;
    exp_w   = hw ? ((r & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh)) : d;
    rd_val      = r;
    req_valid   = 1'b1;
    half_word_t = hw;
    req_addr    = a;
    req_data    = d;
    chk("ready_pre", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    // Inputs are garbage while busy; the store must use latched values.
    req_valid   = $urandom_range(0, 1);
    half_word_t = $urandom_range(0, 1);
    req_addr    = $urandom();
    req_data    = $urandom();
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk("mem_re", {31'd0, mem_re}, {31'd0, c == re_at});
      chk("mem_we", {31'd0, mem_we}, {31'd0, c == we_at});
      chk("done",   {31'd0, done},   {31'd0, c == done_at});
      chk("err",    {31'd0, err},    {31'd0, mis && c == 1});
      chk("ready",  {31'd0, req_ready}, {31'd0, c == lat});
      if (c == re_at || c == we_at) chk("mem_addr", mem_addr, exp_a);
      if (c == we_at) chk("mem_wdata", mem_wdata, exp_w);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_re",    {31'd0, mem_re}, 32'd0);
    chk("rst_we",    {31'd0, mem_we}, 32'd0);
    chk("rst_done",  {31'd0, done},   32'd0);
    chk("rst_err",   {31'd0, err},    32'd0);
    chk("rst_addr",  mem_addr,        32'd0);
    chk("rst_wdata", mem_wdata,       32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_store(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
    do_store(1'b1, 32'h0000_0022, 32'h0000_ABCD, 32'h1122_3344);
    do_store(1'b1, 32'h0000_0020, 32'hFFFF_5678, 32'h1122_3344);
    do_store(1'b0, 32'h0000_0002, 32'h1234_5678, 32'h0);
    do_store(1'b1, 32'h0000_0001, 32'h1234_5678, 32'h0);
    do_store(1'b1, 32'h0000_0103, 32'h1234_5678, 32'h0);
    // Back-to-back: sh followed immediately by sw.
    do_store(1'b1, 32'h0000_0042, 32'h0000_1357, 32'hA5A5_5A5A);
    do_store(1'b0, 32'h0000_0044, 32'hCAFE_F00D, 32'h0);

    // Reset during MERGE of a halfword store.
    rd_val = 32'h1122_3344; req_valid = 1'b1; half_word_t = 1'b1;
    req_addr = 32'h24; req_data = 32'h9999;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_we",    {31'd0, mem_we}, 32'd0);
    chk("mrst_re",    {31'd0, mem_re}, 32'd0);
    chk("mrst_done",  {31'd0, done},   32'd0);
    chk("mrst_addr",  mem_addr,        32'd0);
    chk("mrst_wdata", mem_wdata,       32'd0);
    chk("mrst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_we",    {31'd0, mem_we},    32'd0);
      chk("post_rst_done",  {31'd0, done},      32'd0);
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    end

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = {24'd0, 8'($urandom_range(0, 255))};
      do_store(1'($urandom_range(0, 1)), a, $urandom(), $urandom());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
